// File: rtl/alu_seq.sv
// Multi-cycle ALU: logic/add/sub/compare/shift ops in one cycle, iterative MULU/DIVU/REMU.
// Latency: 1 cycle for single-cycle ops, DATA_WIDTH+1 cycles for MULU/DIVU/REMU.
// Backpressure: one op in flight; result held in DONE until out_ready, new requests only from IDLE.
module alu_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);

  localparam int DW  = DATA_WIDTH;
  localparam int DW1 = DATA_WIDTH + 1;
  localparam int SHW = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [2*DW-1:0]       mcand_q, mcand_d;   // shifted multiplicand
  logic [DW-1:0]         mplier_q, mplier_d; // multiplier (shifted) or divisor
  logic [2*DW-1:0]       acc_q, acc_d;       // product, or remainder in low bits
  logic [DW-1:0]         quot_q, quot_d;     // dividend shifting out, quotient shifting in
  logic [DW-1:0]         res_q, res_d;
  logic                  ovf_q, ovf_d;
  logic                  cy_q, cy_d;

  logic                  sub_en;
  logic [DW-1:0]         b_x;
  logic [DW:0]           sum;
  logic [DW-1:0]         sc_res;
  logic                  sc_ovf, sc_cy;
  logic                  is_multi;

  logic [2*DW-1:0]       mul_acc_nxt;
  logic [DW:0]           trial;
  logic                  ge;
  logic [DW-1:0]         rem_nxt, quot_nxt;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign Result    = res_q;
  assign Overflow  = ovf_q;
  assign CarryOut  = cy_q;
  assign Zero      = (res_q == '0);

  assign is_multi = (ALUop == OP_MULU) || (ALUop == OP_DIVU) || (ALUop == OP_REMU);

  // Single-cycle function unit, evaluated directly on the request operands.
  always_comb begin
    sub_en = (ALUop == OP_SUB);
    b_x    = sub_en ? ~B : B;
    sum    = {1'b0, A} + {1'b0, b_x} + DW1'(sub_en);
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_cy  = 1'b0;
    case (ALUop)
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_XOR:  sc_res = A ^ B;
      OP_NOR:  sc_res = ~(A | B);
      OP_ADD, OP_SUB: begin
        sc_res = sum[DW-1:0];
        sc_ovf = (A[DW-1] == b_x[DW-1]) && (sum[DW-1] != A[DW-1]);
        // For SUB the adder carry is "no borrow", so invert it.
        sc_cy  = sub_en ? ~sum[DW] : sum[DW];
      end
      OP_SLT:  sc_res = {{(DW-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: sc_res = {{(DW-1){1'b0}}, (A < B)};
      OP_SLL:  sc_res = A << B[SHW-1:0];
      OP_SRL:  sc_res = A >> B[SHW-1:0];
      OP_SRA:  sc_res = $unsigned($signed(A) >>> B[SHW-1:0]);
      default: sc_res = '0;
    endcase
  end

  // One iteration of shift-add multiply and of restoring divide.
  always_comb begin
    mul_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    trial       = {acc_q[DW-1:0], quot_q[DW-1]};
    ge          = (trial >= {1'b0, mplier_q});
    // When ge holds, trial - divisor < divisor, so low DW bits are exact.
    rem_nxt     = ge ? (trial[DW-1:0] - mplier_q) : trial[DW-1:0];
    quot_nxt    = {quot_q[DW-2:0], ge};
  end

  // FSM next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    quot_d   = quot_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    cy_d     = cy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = ALUop;
          if (is_multi) begin
            mcand_d  = {{DW{1'b0}}, A};
            mplier_d = B;
            acc_d    = '0;
            quot_d   = A;
            cnt_d    = '0;
            state_d  = BUSY;
          end else begin
            res_d   = sc_res;
            ovf_d   = sc_ovf;
            cy_d    = sc_cy;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MULU) begin
          acc_d    = mul_acc_nxt;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end else begin
          acc_d  = {{DW{1'b0}}, rem_nxt};
          quot_d = quot_nxt;
        end
        if (cnt_q == CNT_WIDTH'(DW - 1)) begin
          ovf_d   = 1'b0;
          cy_d    = 1'b0;
          state_d = DONE;
          if (op_q == OP_MULU)      res_d = mul_acc_nxt[DW-1:0];
          else if (op_q == OP_DIVU) res_d = quot_nxt;
          else                      res_d = rem_nxt;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      quot_q   <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      cy_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      quot_q   <= quot_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      cy_q     <= cy_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases plus random ops against an arithmetic model.
// Checks results, flags, latency, handshake holding and reset abort.
// Every comparison goes through chk().
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic [3:0]  ALUop;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Overflow, CarryOut, Zero;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUop(ALUop), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Overflow(Overflow), .CarryOut(CarryOut), .Zero(Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour computed with plain integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ovf, output logic cy,
                                output int lat);
    logic [32:0]        s;
    logic [63:0]        p;
    logic signed [31:0] sa;
    sa  = a;
    r   = 0;
    ovf = 0;
    cy  = 0;
    lat = 1;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = ~(a | b);
      4'b0010: begin
        s   = {1'b0, a} + {1'b0, b};
        r   = s[31:0];
        cy  = s[32];
        ovf = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0110: begin
        r   = a - b;
        cy  = (a < b);
        ovf = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: r = (a < b) ? 32'd1 : 32'd0;
      4'b1000: r = a << b[4:0];
      4'b1001: r = a >> b[4:0];
      4'b1010: r = sa >>> b[4:0];
      4'b1100: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; lat = 33; end
      4'b1101: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; lat = 33; end
      4'b1110: begin r = (b == 0) ? a : a % b; lat = 33; end
      default: r = 0;
    endcase
  endfunction

  // Issue one op, check latency/result/flags, hold DONE for 'hold' cycles, then retire it.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic        eo, ec;
    int          elat, lat;
    logic        rdy_in_busy;
    model(op, a, b, er, eo, ec, elat);
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    A = a; B = b; ALUop = op; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; ALUop = 4'($urandom);
    lat = 1;
    rdy_in_busy = 1'b0;
    while (!out_valid && lat < 80) begin
      if (in_ready) rdy_in_busy = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, elat);
    if (elat > 1) chk({tag, "_in_ready_busy"}, rdy_in_busy, 0);
    chk({tag, "_result"}, Result, er);
    chk({tag, "_ovf"}, Overflow, eo);
    chk({tag, "_carry"}, CarryOut, ec);
    chk({tag, "_zero"}, Zero, (er == 0));
    chk({tag, "_in_ready_done"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_flags"}, {Result, Overflow, CarryOut, in_ready}, {er, eo, ec, 1'b0});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_retire_valid"}, out_valid, 0);
    chk({tag, "_retire_ready"}, in_ready, 1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen_valid;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = 0; B = 0; ALUop = 0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {Result, Overflow, CarryOut, Zero}, {32'd0, 1'b0, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1, 0);
    run_op("sub_borrow", 4'b0110, 32'd0, 32'd1, 0);
    run_op("slt", 4'b0111, 32'h8000_0000, 32'd1, 0);
    run_op("sltu", 4'b0011, 32'h8000_0000, 32'd1, 0);
    run_op("slt_ovf", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    run_op("mulu", 4'b1100, 32'h0000_FFFF, 32'h0001_0001, 0);
    run_op("divu", 4'b1101, 32'd100, 32'd7, 0);
    run_op("remu", 4'b1110, 32'd100, 32'd7, 0);
    run_op("divu0", 4'b1101, 32'h1234_5678, 32'd0, 0);
    run_op("remu0", 4'b1110, 32'd5, 32'd0, 0);
    run_op("sra", 4'b1010, 32'h8000_0010, 32'd36, 0);
    run_op("bad_op", 4'b1111, 32'hFFFF_FFFF, 32'd3, 0);
    run_op("hold5", 4'b0010, 32'hFFFF_FFFF, 32'd2, 5);

    // Abort a multiply at cnt=10 with reset; no result may appear.
    A = 32'd1234; B = 32'd5678; ALUop = 4'b1100; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_outputs", {Result, Overflow, CarryOut, Zero, in_ready}, {32'd0, 4'b0010});
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid++;
    end
    chk("abort_no_valid", seen_valid, 0);
    run_op("add_after_rst", 4'b0010, 32'd2, 32'd3, 0);

    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      case ($urandom_range(0, 14))
        0: op = 4'b0000;  1: op = 4'b0001;  2: op = 4'b0010;  3: op = 4'b0110;
        4: op = 4'b0111;  5: op = 4'b0011;  6: op = 4'b0100;  7: op = 4'b0101;
        8: op = 4'b1000;  9: op = 4'b1001; 10: op = 4'b1010; 11: op = 4'b1100;
        12: op = 4'b1101; 13: op = 4'b1110;
        default: op = 4'b1011;
      endcase
      run_op("rand", op, pick(), pick(), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
